// File: rtl/rv_enc_pkg.sv
// Shared definitions for the RV32I instruction encoder: op enumeration,
// opcode/funct constants, format and FSM state types, and field packers.
package rv_enc_pkg;

  localparam int OP_BITS = 6;

  typedef enum logic [OP_BITS-1:0] {
    OP_ADD   = 6'd0,  OP_SUB   = 6'd1,  OP_SLL   = 6'd2,  OP_SLT   = 6'd3,
    OP_SLTU  = 6'd4,  OP_XOR   = 6'd5,  OP_SRL   = 6'd6,  OP_SRA   = 6'd7,
    OP_OR    = 6'd8,  OP_AND   = 6'd9,
    OP_ADDI  = 6'd10, OP_SLTI  = 6'd11, OP_SLTIU = 6'd12, OP_XORI  = 6'd13,
    OP_ORI   = 6'd14, OP_ANDI  = 6'd15,
    OP_SLLI  = 6'd16, OP_SRLI  = 6'd17, OP_SRAI  = 6'd18,
    OP_LB    = 6'd19, OP_LH    = 6'd20, OP_LW    = 6'd21, OP_LBU   = 6'd22,
    OP_LHU   = 6'd23,
    OP_SB    = 6'd24, OP_SH    = 6'd25, OP_SW    = 6'd26,
    OP_BEQ   = 6'd27, OP_BNE   = 6'd28, OP_BLT   = 6'd29, OP_BGE   = 6'd30,
    OP_BLTU  = 6'd31, OP_BGEU  = 6'd32,
    OP_LUI   = 6'd33, OP_AUIPC = 6'd34, OP_JAL   = 6'd35, OP_JALR  = 6'd36,
    OP_ECALL = 6'd37, OP_LI    = 6'd38
  } op_e;

  // FMT_LI is internal to the packer; it resolves to FMT_I or FMT_LI2.
  typedef enum logic [3:0] {
    FMT_ILL, FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SYS,
    FMT_LI, FMT_LI2
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_FULL      = 2'd1,
    ST_FULL_PEND = 2'd2
  } state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_B    = 3'b000;
  localparam logic [2:0] F3_H    = 3'b001;
  localparam logic [2:0] F3_W    = 3'b010;
  localparam logic [2:0] F3_BU   = 3'b100;
  localparam logic [2:0] F3_HU   = 3'b101;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [6:0] opc);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:1] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [6:0] opc);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:1] imm, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
  endfunction

endpackage

// File: rtl/rv_enc_pack.sv
// Combinational packer: one symbolic descriptor in, one 32-bit word, its
// resolved format and an immediate-range verdict out.
module rv_enc_pack
  import rv_enc_pkg::*;
(
  input  op_e         op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output fmt_e        fmt,
  output logic        imm_ok
);

  fmt_e        fmt_raw;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        fit12;
  logic        fit13_even;
  logic        fit21_even;
  logic        shamt_ok;
  logic [19:0] li_hi;

  // A value fits N signed bits when every bit from N-1 upward is a copy of the sign.
  assign fit12      = (imm[31:11] == '0) | (imm[31:11] == '1);
  assign fit13_even = ((imm[31:12] == '0) | (imm[31:12] == '1)) & ~imm[0];
  assign fit21_even = ((imm[31:20] == '0) | (imm[31:20] == '1)) & ~imm[0];
  assign shamt_ok   = (imm[31:5] == '0);
  assign li_hi      = imm[31:12] + {19'd0, imm[11]};

  always_comb begin
    fmt_raw = FMT_ILL;
    opc     = '0;
    f3      = F3_ADD;
    f7      = F7_BASE;
    case (op)
      OP_ADD:   begin fmt_raw = FMT_R;   opc = OPC_OP;     f3 = F3_ADD;  end
      OP_SUB:   begin fmt_raw = FMT_R;   opc = OPC_OP;     f3 = F3_ADD;  f7 = F7_ALT; end
      OP_SLL:   begin fmt_raw = FMT_R;   opc = OPC_OP;     f3 = F3_SLL;  end
      OP_SLT:   begin fmt_raw = FMT_R;   opc = OPC_OP;     f3 = F3_SLT;  end
      OP_SLTU:  begin fmt_raw = FMT_R;   opc = OPC_OP;     f3 = F3_SLTU; end
      OP_XOR:   begin fmt_raw = FMT_R;   opc = OPC_OP;     f3 = F3_XOR;  end
      OP_SRL:   begin fmt_raw = FMT_R;   opc = OPC_OP;     f3 = F3_SR;   end
      OP_SRA:   begin fmt_raw = FMT_R;   opc = OPC_OP;     f3 = F3_SR;   f7 = F7_ALT; end
      OP_OR:    begin fmt_raw = FMT_R;   opc = OPC_OP;     f3 = F3_OR;   end
      OP_AND:   begin fmt_raw = FMT_R;   opc = OPC_OP;     f3 = F3_AND;  end
      OP_ADDI:  begin fmt_raw = FMT_I;   opc = OPC_OP_IMM; f3 = F3_ADD;  end
      OP_SLTI:  begin fmt_raw = FMT_I;   opc = OPC_OP_IMM; f3 = F3_SLT;  end
      OP_SLTIU: begin fmt_raw = FMT_I;   opc = OPC_OP_IMM; f3 = F3_SLTU; end
      OP_XORI:  begin fmt_raw = FMT_I;   opc = OPC_OP_IMM; f3 = F3_XOR;  end
      OP_ORI:   begin fmt_raw = FMT_I;   opc = OPC_OP_IMM; f3 = F3_OR;   end
      OP_ANDI:  begin fmt_raw = FMT_I;   opc = OPC_OP_IMM; f3 = F3_AND;  end
      OP_SLLI:  begin fmt_raw = FMT_SH;  opc = OPC_OP_IMM; f3 = F3_SLL;  end
      OP_SRLI:  begin fmt_raw = FMT_SH;  opc = OPC_OP_IMM; f3 = F3_SR;   end
      OP_SRAI:  begin fmt_raw = FMT_SH;  opc = OPC_OP_IMM; f3 = F3_SR;   f7 = F7_ALT; end
      OP_LB:    begin fmt_raw = FMT_I;   opc = OPC_LOAD;   f3 = F3_B;    end
      OP_LH:    begin fmt_raw = FMT_I;   opc = OPC_LOAD;   f3 = F3_H;    end
      OP_LW:    begin fmt_raw = FMT_I;   opc = OPC_LOAD;   f3 = F3_W;    end
      OP_LBU:   begin fmt_raw = FMT_I;   opc = OPC_LOAD;   f3 = F3_BU;   end
      OP_LHU:   begin fmt_raw = FMT_I;   opc = OPC_LOAD;   f3 = F3_HU;   end
      OP_SB:    begin fmt_raw = FMT_S;   opc = OPC_STORE;  f3 = F3_B;    end
      OP_SH:    begin fmt_raw = FMT_S;   opc = OPC_STORE;  f3 = F3_H;    end
      OP_SW:    begin fmt_raw = FMT_S;   opc = OPC_STORE;  f3 = F3_W;    end
      OP_BEQ:   begin fmt_raw = FMT_B;   opc = OPC_BRANCH; f3 = F3_BEQ;  end
      OP_BNE:   begin fmt_raw = FMT_B;   opc = OPC_BRANCH; f3 = F3_BNE;  end
      OP_BLT:   begin fmt_raw = FMT_B;   opc = OPC_BRANCH; f3 = F3_BLT;  end
      OP_BGE:   begin fmt_raw = FMT_B;   opc = OPC_BRANCH; f3 = F3_BGE;  end
      OP_BLTU:  begin fmt_raw = FMT_B;   opc = OPC_BRANCH; f3 = F3_BLTU; end
      OP_BGEU:  begin fmt_raw = FMT_B;   opc = OPC_BRANCH; f3 = F3_BGEU; end
      OP_LUI:   begin fmt_raw = FMT_U;   opc = OPC_LUI;    end
      OP_AUIPC: begin fmt_raw = FMT_U;   opc = OPC_AUIPC;  end
      OP_JAL:   begin fmt_raw = FMT_J;   opc = OPC_JAL;    end
      OP_JALR:  begin fmt_raw = FMT_I;   opc = OPC_JALR;   f3 = F3_ADD;  end
      OP_ECALL: begin fmt_raw = FMT_SYS; opc = OPC_SYSTEM; end
      OP_LI:    begin fmt_raw = FMT_LI;  opc = OPC_OP_IMM; f3 = F3_ADD;  end
      default:  begin fmt_raw = FMT_ILL; end
    endcase
  end

  always_comb begin
    word   = '0;
    fmt    = fmt_raw;
    imm_ok = 1'b0;
    case (fmt_raw)
      FMT_R:   begin word = enc_r(f7, rs2, rs1, f3, rd, opc);      imm_ok = 1'b1;       end
      FMT_I:   begin word = enc_i(imm[11:0], rs1, f3, rd, opc);    imm_ok = fit12;      end
      FMT_SH:  begin word = enc_r(f7, imm[4:0], rs1, f3, rd, opc); imm_ok = shamt_ok;   end
      FMT_S:   begin word = enc_s(imm[11:0], rs2, rs1, f3, opc);   imm_ok = fit12;      end
      FMT_B:   begin word = enc_b(imm[12:1], rs2, rs1, f3, opc);   imm_ok = fit13_even; end
      FMT_U:   begin word = {imm[31:12], rd, opc};                 imm_ok = 1'b1;       end
      FMT_J:   begin word = enc_j(imm[20:1], rd, opc);             imm_ok = fit21_even; end
      FMT_SYS: begin word = enc_i(12'd0, 5'd0, F3_ADD, 5'd0, opc); imm_ok = 1'b1;       end
      FMT_LI: begin
        imm_ok = 1'b1;
        if (fit12) begin
          word = enc_i(imm[11:0], 5'd0, F3_ADD, rd, OPC_OP_IMM);
          fmt  = FMT_I;
        end else begin
          // Upper half is rounded up when imm[11] is set, because the ADDI sign-extends.
          word = {li_hi, rd, OPC_LUI};
          fmt  = FMT_LI2;
        end
      end
      default: begin word = '0; imm_ok = 1'b0; end
    endcase
  end

endmodule

// File: rtl/rv_encoder.sv
// Streaming RV32I encoder: descriptor in, machine word out, one-entry output
// register plus a pending ADDI half for two-beat LI expansion.
module rv_encoder
  import rv_enc_pkg::*;
#(
  parameter int OP_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] in_op,
  input  logic [4:0]      in_rd,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [31:0]     in_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic            out_err
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and out_instr is frozen while
  // out_valid is high and out_ready is low.

  state_e      state_q, state_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic        out_err_q, out_err_d;
  logic [4:0]  pend_rd_q, pend_rd_d;
  logic [11:0] pend_imm_q, pend_imm_d;

  logic [OP_BITS-1:0] op_bits;
  logic               op_in_range;
  logic [31:0]        pk_word;
  fmt_e               pk_fmt;
  logic               pk_imm_ok;
  logic               accept;
  logic               good;
  logic               long_li;
  logic               load_new;
  logic [31:0]        addi_half;

  assign op_bits     = OP_BITS'(in_op);
  assign op_in_range = ((in_op >> OP_BITS) == '0);

  rv_enc_pack u_pack (
    .op     (op_e'(op_bits)),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .imm    (in_imm),
    .word   (pk_word),
    .fmt    (pk_fmt),
    .imm_ok (pk_imm_ok)
  );

  assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_FULL) & out_ready);
  assign out_valid = (state_q != ST_IDLE);
  assign out_instr = out_instr_q;
  assign out_err   = out_err_q;

  assign accept    = in_valid & in_ready;
  assign good      = op_in_range & (pk_fmt != FMT_ILL) & pk_imm_ok;
  assign long_li   = (pk_fmt == FMT_LI2);
  assign addi_half = enc_i(pend_imm_q, pend_rd_q, F3_ADD, pend_rd_q, OPC_OP_IMM);

  always_comb begin
    state_d     = state_q;
    out_instr_d = out_instr_q;
    pend_rd_d   = pend_rd_q;
    pend_imm_d  = pend_imm_q;
    out_err_d   = accept & ~good;
    load_new    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        load_new = accept & good;
      end
      ST_FULL: begin
        if (out_ready) begin
          load_new = accept & good;
          if (!(accept & good)) state_d = ST_IDLE;
        end
      end
      ST_FULL_PEND: begin
        if (out_ready) begin
          out_instr_d = addi_half;
          pend_rd_d   = '0;
          pend_imm_d  = '0;
          state_d     = ST_FULL;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (load_new) begin
      out_instr_d = pk_word;
      state_d     = long_li ? ST_FULL_PEND : ST_FULL;
      if (long_li) begin
        pend_rd_d  = in_rd;
        pend_imm_d = in_imm[11:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_instr_q <= '0;
      out_err_q   <= 1'b0;
      pend_rd_q   <= '0;
      pend_imm_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_instr_q <= out_instr_d;
      out_err_q   <= out_err_d;
      pend_rd_q   <= pend_rd_d;
      pend_imm_q  <= pend_imm_d;
    end
  end

endmodule

// File: tb/tb_rv_encoder.sv
// Bench for rv_encoder: directed encodings, backpressure, reset in the middle
// of an LI expansion, and random streams against an arithmetic reference model.
module tb_rv_encoder;
  import rv_enc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_op;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;

  rv_encoder #(.OP_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  bit          cur_rej;
  int          cur_nw;
  logic [31:0] cur_w0, cur_w1;
  bit          acc_flag;
  int          stall_cnt = 0;
  int          rdy_pct = 100;
  bit          stalled_prev = 0;
  logic [31:0] last_word = '0;

  int R_F3[10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
  int I_F3[6]  = '{0, 2, 3, 4, 6, 7};
  int SH_F3[3] = '{1, 5, 5};
  int LD_F3[5] = '{0, 1, 2, 4, 5};
  int BR_F3[6] = '{0, 1, 4, 5, 6, 7};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic void ref_model(input int op, input logic [4:0] rd, input logic [4:0] rs1,
                                    input logic [4:0] rs2, input logic [31:0] imm,
                                    output bit rej, output int nw,
                                    output logic [31:0] w0, output logic [31:0] w1);
    int          si;
    bit          fit12;
    logic [31:0] r, a, b;
    si    = int'($signed(imm));
    fit12 = (si >= -2048) && (si <= 2047);
    r     = 32'(rd) << 7;
    a     = 32'(rs1) << 15;
    b     = 32'(rs2) << 20;
    rej   = 0;
    nw    = 1;
    w0    = '0;
    w1    = '0;
    if (op <= 9) begin
      w0 = ((op == 1 || op == 7) ? 32'h4000_0000 : 32'h0) | b | a | (R_F3[op] << 12) | r | 32'h33;
    end else if (op <= 15) begin
      rej = !fit12;
      w0  = (imm << 20) | a | (I_F3[op-10] << 12) | r | 32'h13;
    end else if (op <= 18) begin
      rej = (imm > 32'd31);
      w0  = ((op == 18) ? 32'h4000_0000 : 32'h0) | ((imm & 32'd31) << 20) | a
            | (SH_F3[op-16] << 12) | r | 32'h13;
    end else if (op <= 23) begin
      rej = !fit12;
      w0  = (imm << 20) | a | (LD_F3[op-19] << 12) | r | 32'h03;
    end else if (op <= 26) begin
      rej = !fit12;
      w0  = (((imm >> 5) & 32'd127) << 25) | b | a | ((op - 24) << 12)
            | ((imm & 32'd31) << 7) | 32'h23;
    end else if (op <= 32) begin
      rej = (si < -4096) || (si > 4095) || imm[0];
      w0  = (((imm >> 12) & 32'd1) << 31) | (((imm >> 5) & 32'd63) << 25) | b | a
            | (BR_F3[op-27] << 12) | (((imm >> 1) & 32'd15) << 8)
            | (((imm >> 11) & 32'd1) << 7) | 32'h63;
    end else if (op == 33) begin
      w0 = (imm & 32'hFFFF_F000) | r | 32'h37;
    end else if (op == 34) begin
      w0 = (imm & 32'hFFFF_F000) | r | 32'h17;
    end else if (op == 35) begin
      rej = (si < -1048576) || (si > 1048575) || imm[0];
      w0  = (((imm >> 20) & 32'd1) << 31) | (((imm >> 1) & 32'd1023) << 21)
            | (((imm >> 11) & 32'd1) << 20) | (((imm >> 12) & 32'd255) << 12) | r | 32'h6F;
    end else if (op == 36) begin
      rej = !fit12;
      w0  = (imm << 20) | a | r | 32'h67;
    end else if (op == 37) begin
      w0 = 32'h73;
    end else if (op == 38) begin
      if (fit12) begin
        w0 = (imm << 20) | r | 32'h13;
      end else begin
        nw = 2;
        w0 = ((((imm >> 12) + ((imm >> 11) & 32'd1)) & 32'hFFFFF) << 12) | r | 32'h37;
        w1 = (imm << 20) | (32'(rd) << 15) | r | 32'h13;
      end
    end else begin
      rej = 1;
    end
    if (rej) nw = 0;
  endfunction

  function automatic logic [31:0] rand_imm(input int op);
    if (op >= 16 && op <= 18) return 32'($urandom_range(0, 31));
    if (op >= 27 && op <= 32) return 32'(int'($urandom_range(0, 4095)) - 2048) << 1;
    if (op == 35) return 32'(int'($urandom_range(0, 1048575)) - 524288) << 1;
    if (op == 33 || op == 34 || op == 37) return $urandom;
    if (op == 38 && $urandom_range(0, 1) == 1) return $urandom;
    return 32'(int'($urandom_range(0, 4095)) - 2048);
  endfunction

  // ---------------- one clock of driving and checking ----------------
  task automatic run_cycle();
    bit err_next;
    bit in_reset;
    err_next = 0;
    acc_flag = 0;
    @(negedge clk);
    in_reset = rst;
    if (!in_reset) begin
      check("in_ready", 32'(in_ready), 32'((exp_q.size() == 0) || (exp_q.size() == 1 && out_ready)));
      if (stalled_prev) check("held_word", out_instr, last_word);
      stalled_prev = out_valid && !out_ready;
      last_word    = out_instr;
      if (out_valid && out_ready && exp_q.size() > 0) check("beat", out_instr, exp_q.pop_front());
      if (in_valid && in_ready) begin
        acc_flag = 1;
        err_next = cur_rej;
        if (cur_nw > 0) exp_q.push_back(cur_w0);
        if (cur_nw > 1) exp_q.push_back(cur_w1);
      end
    end else begin
      if (out_valid === 1'b1 && out_ready && exp_q.size() > 0) check("beat", out_instr, exp_q.pop_front());
      stalled_prev = 0;
    end
    @(posedge clk);
    #1;
    if (in_reset) exp_q.delete();
    check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
    check("out_err", 32'(out_err), 32'(err_next));
    if (stall_cnt > 0) begin
      out_ready = 1'b0;
      stall_cnt--;
    end else begin
      out_ready = ($urandom_range(1, 100) <= rdy_pct);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input int op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm, input bit rej,
                      input int nw, input logic [31:0] w0, input logic [31:0] w1);
    in_valid = 1'b1;
    in_op    = 6'(op);
    in_rd    = rd;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_imm   = imm;
    cur_rej  = rej;
    cur_nw   = nw;
    cur_w0   = w0;
    cur_w1   = w1;
    for (int i = 0; i < 64; i++) begin
      run_cycle();
      if (acc_flag) break;
    end
    check("accepted", 32'(acc_flag), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic send_model(input int op, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [31:0] imm);
    bit          rej;
    int          nw;
    logic [31:0] w0, w1;
    ref_model(op, rd, rs1, rs2, imm, rej, nw, w0, w1);
    send(op, rd, rs1, rs2, imm, rej, nw, w0, w1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) run_cycle();
    check("drained", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = '0;
    in_rd     = '0;
    in_rs1    = '0;
    in_rs2    = '0;
    in_imm    = '0;
    out_ready = 1'b1;

    idle(2);
    check("rst_out_instr", out_instr, 32'h0);
    rst = 1'b0;
    idle(1);

    // Directed encodings from hand-computed words.
    send(OP_ADD,  5'd3, 5'd1, 5'd2, 32'd0,  0, 1, 32'h002081B3, 32'h0);
    send(OP_SRAI, 5'd1, 5'd1, 5'd0, 32'd3,  0, 1, 32'h4030D093, 32'h0);
    send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 0, 1, 32'hFFF00093, 32'h0);
    idle(2);
    send(OP_SW,   5'd0, 5'd1, 5'd2, 32'd4,  0, 1, 32'h0020A223, 32'h0);
    send(OP_BEQ,  5'd0, 5'd1, 5'd2, 32'd8,  0, 1, 32'h00208463, 32'h0);
    send(OP_BEQ,  5'd0, 5'd1, 5'd2, 32'd7,  1, 0, 32'h0, 32'h0);
    send(OP_ADD,  5'd3, 5'd1, 5'd2, 32'd0,  0, 1, 32'h002081B3, 32'h0);
    send(OP_LI,   5'd5, 5'd0, 5'd0, 32'h12345FFF, 0, 2, 32'h123462B7, 32'hFFF28293);
    send(OP_LI,   5'd5, 5'd0, 5'd0, 32'd100, 0, 1, 32'h06400293, 32'h0);
    send(OP_ECALL, 5'd7, 5'd9, 5'd11, 32'd5, 0, 1, 32'h00000073, 32'h0);
    drain();

    // Immediate boundaries and illegal op codes through the model.
    send_model(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd2047);
    send_model(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd2048);
    send_model(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800);
    send_model(OP_SLLI, 5'd2, 5'd3, 5'd0, 32'd31);
    send_model(OP_SLLI, 5'd2, 5'd3, 5'd0, 32'd32);
    send_model(OP_BNE,  5'd0, 5'd4, 5'd5, 32'hFFFF_F000);
    send_model(OP_BNE,  5'd0, 5'd4, 5'd5, 32'd4096);
    send_model(OP_JAL,  5'd1, 5'd0, 5'd0, 32'h000F_FFFE);
    send_model(OP_JAL,  5'd1, 5'd0, 5'd0, 32'd3);
    send_model(OP_LUI,  5'd9, 5'd0, 5'd0, 32'hABCDE123);
    send_model(OP_LI,   5'd6, 5'd0, 5'd0, 32'hFFFF_F7FF);
    send_model(OP_LI,   5'd6, 5'd0, 5'd0, 32'h0000_0800);
    send_model(50,      5'd1, 5'd2, 5'd3, 32'd0);
    drain();

    // Backpressure: hold one word for three cycles while the next one waits.
    send_model(OP_ADD, 5'd10, 5'd11, 5'd12, 32'd0);
    out_ready = 1'b0;
    stall_cnt = 2;
    send_model(OP_SUB, 5'd13, 5'd14, 5'd15, 32'd0);
    drain();

    // Reset while the LUI half is being taken: the ADDI half must vanish.
    send(OP_LI, 5'd5, 5'd0, 5'd0, 32'h12345FFF, 0, 2, 32'h123462B7, 32'hFFF28293);
    rst       = 1'b1;
    out_ready = 1'b1;
    run_cycle();
    rst = 1'b0;
    check("rst_mid_instr", out_instr, 32'h0);
    idle(3);

    // Back-to-back legal stream with random backpressure.
    rdy_pct = 60;
    for (int i = 0; i < 20; i++) begin
      int op;
      op = int'($urandom_range(0, 38));
      send_model(op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)), rand_imm(op));
    end
    drain();

    // Mixed stream including illegal ops and out-of-range immediates.
    for (int i = 0; i < 40; i++) begin
      int          op;
      logic [31:0] imm;
      op = int'($urandom_range(0, 63));
      case ($urandom_range(0, 2))
        0:       imm = rand_imm(op);
        1:       imm = $urandom;
        default: imm = 32'(int'($urandom_range(0, 8191)) - 4096);
      endcase
      send_model(op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)), imm);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    rdy_pct = 100;
    drain();
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
